// File: rtl/button_press_encoder_if.sv
// ----------------------------------------------------------------------------
// press_if : one-entry valid/ready event channel from the button encoder to
// the hit checker.
//   valid : event pending (producer -> consumer)
//   idx   : index of the pressed button, button1 = 0 .. button4 = 3
//   multi : more than one button rose in the captured cycle
//   ready : consumer takes the event when ready & valid (consumer -> producer)
// ----------------------------------------------------------------------------
interface press_if;
    logic       valid;
    logic       ready;
    logic [1:0] idx;
    logic       multi;

    modport master (output valid, output idx, output multi, input  ready);
    modport slave  (input  valid, input  idx, input  multi, output ready);
endinterface

// File: rtl/button_press_encoder.sv
// ----------------------------------------------------------------------------
// button_press_encoder : player-side front end for the four game buttons.
// Each raw button is synchronised (2 FFs), debounced, and its press (rising)
// edge is encoded into a 2-bit index plus a multi-press flag, presented on a
// one-entry valid/ready channel. Release edges produce no events.
//
// Ports
//   clk_i              system clock, rising edge
//   rst_ni             asynchronous reset, active-low
//   enable_i           1 = capture presses; 0 = ignore, flush pending, clear overrun
//   button1_i..4_i     raw buttons, 1 = pressed, asynchronous to clk_i
//   press              press_if master: valid / idx / multi out, ready in
//   overrun_o          sticky: a press was dropped while an event was pending
//   held_o             debounced levels, bit0 = button1
// ----------------------------------------------------------------------------
module button_press_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         enable_i,
    input  logic         button1_i,
    input  logic         button2_i,
    input  logic         button3_i,
    input  logic         button4_i,
    press_if.master      press,
    output logic         overrun_o,
    output logic [3:0]   held_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // Lowest set bit wins; callers only use it when at least one bit is set.
    function automatic logic [1:0] lowest_idx(input logic [3:0] v);
        logic [1:0] r;
        if (v[0]) begin
            r = 2'd0;
        end else if (v[1]) begin
            r = 2'd1;
        end else if (v[2]) begin
            r = 2'd2;
        end else begin
            r = 2'd3;
        end
        return r;
    endfunction

    // More than one bit set: clearing the lowest set bit leaves something.
    function automatic logic more_than_one(input logic [3:0] v);
        return ((v & (v - 4'd1)) != 4'd0);
    endfunction

    logic [3:0]       raw_s;
    logic [3:0]       sync1_q;
    logic [3:0]       sync2_q;
    logic [3:0]       stable_q;
    logic [3:0]       stable_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [3:0]       rise_q;
    logic [3:0]       rise_d;

    state_e           state_q;
    logic             valid_q;
    logic [1:0]       idx_q;
    logic             multi_q;
    logic             overrun_q;

    assign raw_s = {button4_i, button3_i, button2_i, button1_i};

    // Two-flop synchroniser for the asynchronous button inputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 4'b0000;
            sync2_q <= 4'b0000;
        end else begin
            sync1_q <= raw_s;
            sync2_q <= sync1_q;
        end
    end

    // Debounce next-state: a new level is accepted only after it has differed
    // from the accepted level for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
        // Rise is taken against the next level so the registered pulse
        // lines up with the cycle the level is accepted.
        rise_d = stable_d & ~stable_q;
    end

    // Debounce state, accepted levels and registered rise pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stable_q <= 4'b0000;
            rise_q   <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            rise_q   <= rise_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Event FSM: captures rises into the one-entry channel, tracks overrun.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            valid_q   <= 1'b0;
            idx_q     <= 2'd0;
            multi_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else if (!enable_i) begin
            // Disabled: pending event discarded, overrun cleared, rises ignored.
            state_q   <= ST_IDLE;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|rise_q) begin
                        idx_q   <= lowest_idx(rise_q);
                        multi_q <= more_than_one(rise_q);
                        valid_q <= 1'b1;
                        state_q <= ST_HOLD;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (press.ready) begin
                        if (|rise_q) begin
                            // Back-to-back: accepted event replaced in the same cycle.
                            idx_q   <= lowest_idx(rise_q);
                            multi_q <= more_than_one(rise_q);
                            valid_q <= 1'b1;
                            state_q <= ST_HOLD;
                        end else begin
                            valid_q <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end else if (|rise_q) begin
                        overrun_q <= 1'b1;
                    end else begin
                        state_q <= ST_HOLD;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign press.valid = valid_q;
    assign press.idx   = idx_q;
    assign press.multi = multi_q;
    assign overrun_o   = overrun_q;
    assign held_o      = stable_q;

endmodule

// File: tb/tb_button_press_encoder.sv
// ----------------------------------------------------------------------------
// tb_button_press_encoder : directed scenarios followed by random button,
// ready and enable activity. A reference model tracks the expected outputs
// from the behavioural rules: a debounced level changes once the synchronised
// input has disagreed with it for D consecutive samples, rises are queued into
// a single-slot channel, and drops while full set overrun.
// ----------------------------------------------------------------------------
module tb_button_press_encoder;

    localparam int D = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b1;
    logic [3:0] btn   = 4'b0000;
    logic       ov;
    logic [3:0] held;

    press_if p ();

    button_press_encoder #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .enable_i  (en),
        .button1_i (btn[0]),
        .button2_i (btn[1]),
        .button3_i (btn[2]),
        .button4_i (btn[3]),
        .press     (p.master),
        .overrun_o (ov),
        .held_o    (held)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [3:0] raw_hist[$];   // raw samples taken at previous edges, newest last
    logic [3:0] m_stable;
    logic [3:0] m_rise;        // rise produced at the previous edge
    logic       m_valid;
    logic [1:0] m_idx;
    logic       m_multi;
    logic       m_ov;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        raw_hist = {};
        for (int i = 0; i < D + 2; i++) raw_hist.push_back(4'b0000);
        m_stable = 4'b0000;
        m_rise   = 4'b0000;
        m_valid  = 1'b0;
        m_idx    = 2'd0;
        m_multi  = 1'b0;
        m_ov     = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        logic [3:0] nstable;
        int         sz;
        bit         all_diff;
        if (!rst_n) begin
            model_reset();
            return;
        end
        // Synchronised value at this edge is the raw sample from two edges ago;
        // the last D synchronised samples are raw_hist[sz-2] back to raw_hist[sz-1-D].
        sz      = raw_hist.size();
        nstable = m_stable;
        for (int b = 0; b < 4; b++) begin
            all_diff = 1'b1;
            for (int j = 0; j < D; j++) begin
                if (raw_hist[sz-2-j][b] == m_stable[b]) all_diff = 1'b0;
            end
            if (all_diff) nstable[b] = ~m_stable[b];
        end
        // Channel behaviour using the rise visible before this edge.
        if (!en) begin
            m_valid = 1'b0;
            m_ov    = 1'b0;
        end else if (m_rise != 4'b0000) begin
            if (!m_valid || p.ready) begin
                m_valid = 1'b1;
                for (int b = 3; b >= 0; b--) if (m_rise[b]) m_idx = 2'(b);
                m_multi = ($countones(m_rise) > 1);
            end else begin
                m_ov = 1'b1;
            end
        end else if (m_valid && p.ready) begin
            m_valid = 1'b0;
        end
        m_rise   = nstable & ~m_stable;
        m_stable = nstable;
        raw_hist.push_back(btn);
        void'(raw_hist.pop_front());
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"},   {3'b000, p.valid}, {3'b000, m_valid});
        chk({tag, ".idx"},     {2'b00, p.idx},    {2'b00, m_idx});
        chk({tag, ".multi"},   {3'b000, p.multi}, {3'b000, m_multi});
        chk({tag, ".overrun"}, {3'b000, ov},      {3'b000, m_ov});
        chk({tag, ".held"},    held,              m_stable);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        int  n;
        int  pulses;
        int  hi_cycles;
        bit  saw_valid;
        logic [1:0] idxs[$];
        logic       prev_valid;

        p.ready = 1'b0;
        model_reset();
        step("reset");
        step("reset");
        #2 rst_n = 1'b1;
        step("post_reset");

        // 1. Press button3, then reset asynchronously while the event is pending.
        en = 1'b1; p.ready = 1'b0; btn = 4'b0100;
        for (int i = 0; i < 8; i++) step("t1_press");
        chk("t1_valid_before_rst", {3'b000, p.valid}, 4'h1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all("t1_async_rst");
        chk("t1_rst_valid", {3'b000, p.valid}, 4'h0);
        chk("t1_rst_held", held, 4'b0000);
        step("t1_in_rst");
        #2 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step("t1_rerelease");
            chk("t1_held_during_db", held, 4'b0000);
        end
        step("t1_accept");
        chk("t1_held_accept", held, 4'b0100);
        step("t1_event");
        p.ready = 1'b1;
        step("t1_consume");
        btn = 4'b0000;
        for (int i = 0; i < 10; i++) step("t1_release");

        // 2. Bouncing button3 with ready low: single event at settle + D + 3 edges.
        p.ready = 1'b0;
        btn = 4'b0100; step("t2_bounce");
        btn = 4'b0000; step("t2_bounce");
        btn = 4'b0100; step("t2_bounce");
        btn = 4'b0000; step("t2_bounce");
        btn = 4'b0100;
        n = 0;
        while (!p.valid && n < 20) begin
            step("t2_settle");
            n++;
        end
        chk("t2_latency", 4'(n), 4'(D + 3));
        chk("t2_idx", {2'b00, p.idx}, 4'h2);
        chk("t2_multi", {3'b000, p.multi}, 4'h0);
        chk("t2_held", held, 4'b0100);
        for (int i = 0; i < 6; i++) step("t2_hold");
        chk("t2_still_valid", {3'b000, p.valid}, 4'h1);
        p.ready = 1'b1;
        step("t2_consume");
        chk("t2_consumed", {3'b000, p.valid}, 4'h0);
        btn = 4'b0000;
        for (int i = 0; i < 10; i++) step("t2_release");

        // 3. button2 high for fewer than D synchronised cycles: rejected.
        btn = 4'b0010;
        for (int i = 0; i < 3; i++) step("t3_glitch");
        btn = 4'b0000;
        saw_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step("t3_quiet");
            if (p.valid) saw_valid = 1'b1;
            chk("t3_held", held, 4'b0000);
        end
        chk("t3_no_event", {3'b000, saw_valid}, 4'h0);

        // 4. button1 and button4 together: lowest index with multi set.
        p.ready = 1'b0;
        btn = 4'b1001;
        n = 0;
        while (!p.valid && n < 20) begin
            step("t4_wait");
            n++;
        end
        chk("t4_latency", 4'(n), 4'(D + 3));
        chk("t4_idx", {2'b00, p.idx}, 4'h0);
        chk("t4_multi", {3'b000, p.multi}, 4'h1);
        chk("t4_held", held, 4'b1001);
        p.ready = 1'b1;
        step("t4_consume");
        btn = 4'b0000;
        for (int i = 0; i < 10; i++) step("t4_release");

        // 5. Second press while the first is pending: dropped, overrun set.
        p.ready = 1'b0;
        btn = 4'b0010;
        n = 0;
        while (!p.valid && n < 20) begin
            step("t5_wait");
            n++;
        end
        chk("t5_first_valid", {3'b000, p.valid}, 4'h1);
        btn = 4'b0110;
        for (int i = 0; i < 10; i++) step("t5_second");
        chk("t5_idx_kept", {2'b00, p.idx}, 4'h1);
        chk("t5_overrun", {3'b000, ov}, 4'h1);
        en = 1'b0;
        step("t5_disable");
        chk("t5_flush_valid", {3'b000, p.valid}, 4'h0);
        chk("t5_clear_overrun", {3'b000, ov}, 4'h0);
        btn = 4'b0000;
        for (int i = 0; i < 10; i++) step("t5_release");
        en = 1'b1;

        // 6. Two separated presses with ready high: two one-cycle pulses.
        p.ready = 1'b1;
        pulses = 0; hi_cycles = 0; prev_valid = 1'b0; idxs = {};
        for (int i = 0; i < 45; i++) begin
            btn[0] = (i < 10);
            btn[3] = (i >= 20 && i < 30);
            step("t6_run");
            if (p.valid) hi_cycles++;
            if (p.valid && !prev_valid) begin
                pulses++;
                idxs.push_back(p.idx);
            end
            prev_valid = p.valid;
        end
        chk("t6_pulses", 4'(pulses), 4'h2);
        chk("t6_hi_cycles", 4'(hi_cycles), 4'h2);
        if (idxs.size() == 2) begin
            chk("t6_idx_first", {2'b00, idxs[0]}, 4'h0);
            chk("t6_idx_second", {2'b00, idxs[1]}, 4'h3);
        end
        chk("t6_overrun", {3'b000, ov}, 4'h0);

        // Random activity against the model.
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 7) == 0) btn[b] = ~btn[b];
            end
            p.ready = 1'($urandom_range(0, 1));
            en      = ($urandom_range(0, 15) != 0);
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
